// File: rtl/dma_burst_engine_if.sv
// Host-FIFO and MIG user-port bundle for dma_burst_engine.
// master = engine side, slave = FIFO/MIG side.
interface dma_burst_engine_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned CNT_W      = 11
);
    logic                    ib_re;
    logic [DATA_WIDTH-1:0]   ib_data;
    logic                    ib_valid;
    logic [CNT_W-1:0]        ib_count;

    logic                    ob_we;
    logic [DATA_WIDTH-1:0]   ob_data;
    logic [CNT_W-1:0]        ob_count;

    logic                    cmd_en;
    logic [2:0]              cmd_instr;
    logic [ADDR_WIDTH-1:0]   cmd_byte_addr;
    logic [5:0]              cmd_bl;
    logic                    cmd_full;

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_mask;
    logic                    wr_full;

    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_empty;

    modport master (
        output ib_re, input ib_data, ib_valid, ib_count,
        output ob_we, ob_data, input ob_count,
        output cmd_en, cmd_instr, cmd_byte_addr, cmd_bl, input cmd_full,
        output wr_en, wr_data, wr_mask, input wr_full,
        output rd_en, input rd_data, rd_empty
    );

    modport slave (
        input ib_re, output ib_data, ib_valid, ib_count,
        input ob_we, ob_data, output ob_count,
        input cmd_en, cmd_instr, cmd_byte_addr, cmd_bl, output cmd_full,
        input wr_en, wr_data, wr_mask, output wr_full,
        input rd_en, output rd_data, rd_empty
    );
endinterface

// File: rtl/dma_burst_engine.sv
// Multi-burst DMA between host FIFOs and one MIG user port.
// Write mode streams input FIFO -> DDR, read mode streams DDR -> output FIFO.
module dma_burst_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  calib_done,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [15:0]           burst_num,
    output logic                  busy,
    output logic                  done,
    dma_burst_engine_if.master    bus
);
    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        StIdle, StWWait, StWData, StWCmd, StRWait, StRCmd, StRData, StFinish
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             rem_q, rem_d;
    logic [BW-1:0]           req_q, req_d;
    logic [BW-1:0]           wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d, hold_q, hold_d, ob_data_q, ob_data_d;
    logic                    out_vld_q, out_vld_d, hold_vld_q, hold_vld_d;
    logic                    ob_we_q, ob_we_d, done_q, done_d;
    logic                    ib_re, wr_en, cmd_en, rd_en;
    logic [2:0]              cmd_instr;
    logic [1:0]              occ;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        req_d      = req_q;
        wcnt_d     = wcnt_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;
        ib_re      = 1'b0;
        wr_en      = 1'b0;
        cmd_en     = 1'b0;
        cmd_instr  = 3'b000;
        rd_en      = 1'b0;
        occ        = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d = start_addr;
                    rem_d  = burst_num;
                    if (burst_num == 16'd0) state_d = StFinish;
                    else                    state_d = mode ? StRWait : StWWait;
                end
            end
            StWWait: begin
                req_d  = '0;
                wcnt_d = '0;
                if (calib_done && bus.ib_count >= CNT_W'(BURST_LEN)) state_d = StWData;
            end
            StWData: begin
                wr_en = out_vld_q && !bus.wr_full;
                // Words held or in flight after this cycle must leave room for one more
                occ   = 2'(out_vld_q) + 2'(hold_vld_q) + 2'(bus.ib_valid);
                ib_re = (req_q < BW'(BURST_LEN)) && ((occ - 2'(wr_en)) <= 2'd1);
                if (ib_re) req_d = req_q + 1'b1;
                if (wr_en) wcnt_d = wcnt_q + 1'b1;
                if (!out_vld_q || wr_en) begin
                    if (hold_vld_q) begin
                        out_d      = hold_q;
                        out_vld_d  = 1'b1;
                        hold_vld_d = 1'b0;
                        if (bus.ib_valid) begin
                            hold_d     = bus.ib_data;
                            hold_vld_d = 1'b1;
                        end
                    end else if (bus.ib_valid) begin
                        out_d     = bus.ib_data;
                        out_vld_d = 1'b1;
                    end else begin
                        out_vld_d = 1'b0;
                    end
                end else if (bus.ib_valid) begin
                    hold_d     = bus.ib_data;
                    hold_vld_d = 1'b1;
                end
                if (wr_en && wcnt_q == BW'(BURST_LEN - 1)) state_d = StWCmd;
            end
            StWCmd: begin
                if (!bus.cmd_full) begin
                    cmd_en  = 1'b1;
                    addr_d  = addr_q + AddrStep;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? StFinish : StWWait;
                end
            end
            StRWait: begin
                req_d = '0;
                if (calib_done && bus.ob_count <= CNT_W'(FIFO_DEPTH - BURST_LEN)) begin
                    state_d = StRCmd;
                end
            end
            StRCmd: begin
                cmd_instr = 3'b001;
                if (!bus.cmd_full) begin
                    cmd_en  = 1'b1;
                    addr_d  = addr_q + AddrStep;
                    rem_d   = rem_q - 16'd1;
                    state_d = StRData;
                end
            end
            StRData: begin
                rd_en = !bus.rd_empty && (req_q < BW'(BURST_LEN));
                if (rd_en) begin
                    req_d = req_q + 1'b1;
                    if (req_q == BW'(BURST_LEN - 1)) begin
                        state_d = (rem_q == 16'd0) ? StFinish : StRWait;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ob_we_d   = rd_en;
        ob_data_d = rd_en ? bus.rd_data : ob_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            req_q      <= '0;
            wcnt_q     <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ob_data_q  <= '0;
            ob_we_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            req_q      <= req_d;
            wcnt_q     <= wcnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ob_data_q  <= ob_data_d;
            ob_we_q    <= ob_we_d;
            done_q     <= done_d;
        end
    end

    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign bus.ib_re         = ib_re;
    assign bus.ob_we         = ob_we_q;
    assign bus.ob_data       = ob_data_q;
    assign bus.cmd_en        = cmd_en;
    assign bus.cmd_instr     = cmd_instr;
    assign bus.cmd_byte_addr = addr_q;
    assign bus.cmd_bl        = 6'(BURST_LEN - 1);
    assign bus.wr_en         = wr_en;
    assign bus.wr_data       = out_q;
    assign bus.wr_mask       = '0;
    assign bus.rd_en         = rd_en;
endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine with FIFO/MIG behavioural models.
module tb_dma_burst_engine;
    logic        clk = 1'b0;
    logic        reset, calib_done, start, mode;
    logic [29:0] start_addr;
    logic [15:0] burst_num;
    logic        busy, done;

    dma_burst_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .CNT_W(11)) bus ();

    dma_burst_engine #(
        .DATA_WIDTH(32), .BURST_LEN(32), .FIFO_DEPTH(1024), .ADDR_WIDTH(30)
    ) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done), .start(start), .mode(mode),
        .start_addr(start_addr), .burst_num(burst_num), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, last_cmd_cyc = 0, last_ob_cyc = 0;
    int wr_viol = 0, ib_word = 0, rd_idx = 0;
    bit pending_re = 0, pending_rd = 0, wr_toggle = 0, wr_full_r = 0, ib_valid_r = 0;
    logic [31:0] ib_data_r = '0, rd_data_r = 32'hB000_0000;
    logic [31:0] wr_q[$], ob_q[$], cmd_addr_q[$];
    logic [2:0]  cmd_instr_q[$];
    int          cmd_wrcnt_q[$];

    assign bus.wr_full  = wr_full_r;
    assign bus.ib_valid = ib_valid_r;
    assign bus.ib_data  = ib_data_r;
    assign bus.rd_data  = rd_data_r;

    // Monitor: samples mid-cycle
    always @(negedge clk) begin
        cyc++;
        pending_re = bus.ib_re;
        pending_rd = bus.rd_en;
        if (bus.wr_en) begin
            wr_q.push_back(bus.wr_data);
            if (bus.wr_full) wr_viol++;
        end
        if (bus.cmd_en) begin
            cmd_addr_q.push_back(32'(bus.cmd_byte_addr));
            cmd_instr_q.push_back(bus.cmd_instr);
            cmd_wrcnt_q.push_back(wr_q.size());
            last_cmd_cyc = cyc;
        end
        if (bus.ob_we) begin
            ob_q.push_back(bus.ob_data);
            last_ob_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;
    end

    // Input FIFO (1-cycle read latency), FWFT MIG read port, write backpressure
    always @(posedge clk) begin
        #1;
        ib_valid_r = pending_re;
        if (pending_re) begin
            ib_data_r = 32'hA000_0000 + 32'(ib_word);
            ib_word++;
        end
        if (pending_rd) rd_idx++;
        rd_data_r = 32'hB000_0000 + 32'(rd_idx);
        wr_full_r = wr_toggle ? ~wr_full_r : 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit m, input logic [29:0] a, input logic [15:0] n);
        mode = m; start_addr = a; burst_num = n; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b, expected 00", {busy, done}); end
        n_tests++; if ({bus.ib_re, bus.ob_we, bus.cmd_en, bus.wr_en, bus.rd_en} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b, expected 00000", {bus.ib_re, bus.ob_we, bus.cmd_en, bus.wr_en, bus.rd_en}); end
        n_tests++; if (bus.cmd_instr !== 3'b000 || bus.cmd_byte_addr !== 30'h0) begin n_fail++; $display("FAIL reset_cmd: got %b/%h, expected 000/0", bus.cmd_instr, bus.cmd_byte_addr); end
        n_tests++; if (bus.wr_data !== 32'h0 || bus.ob_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h, expected 0/0", bus.wr_data, bus.ob_data); end
        n_tests++; if (bus.cmd_bl !== 6'd31 || bus.wr_mask !== 4'h0) begin n_fail++; $display("FAIL const_bl_mask: got %0d/%h, expected 31/0", bus.cmd_bl, bus.wr_mask); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_write();
        int w0 = wr_q.size(), c0 = cmd_addr_q.size(), d0 = done_cnt, b0 = ib_word, bad = 0;
        bit ok;
        bus.ib_count = 11'd64;
        pulse_start(1'b0, 30'h100, 16'd2);
        wait_done(d0, 2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wr_done_timeout: got no done, expected done"); end
        n_tests++; if (wr_q.size() - w0 !== 64) begin n_fail++; $display("FAIL wr_count: got %0d, expected 64", wr_q.size() - w0); end
        for (int i = 0; i < 64; i++)
            if (w0 + i >= wr_q.size() || wr_q[w0+i] !== 32'hA000_0000 + 32'(b0 + i)) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wr_order: got %0d bad words, expected 0", bad); end
        n_tests++; if (cmd_addr_q.size() - c0 !== 2) begin n_fail++; $display("FAIL wr_cmd_count: got %0d, expected 2", cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h100 || cmd_addr_q[c0+1] !== 32'h180) begin n_fail++; $display("FAIL wr_cmd_addr: got %h %h, expected 100 180", cmd_addr_q[c0], cmd_addr_q[c0+1]); end
            n_tests++; if (cmd_instr_q[c0] !== 3'b000 || cmd_instr_q[c0+1] !== 3'b000) begin n_fail++; $display("FAIL wr_cmd_instr: got %b %b, expected 000 000", cmd_instr_q[c0], cmd_instr_q[c0+1]); end
            n_tests++; if (cmd_wrcnt_q[c0] - w0 !== 32 || cmd_wrcnt_q[c0+1] - w0 !== 64) begin n_fail++; $display("FAIL wr_cmd_after_data: got %0d %0d, expected 32 64", cmd_wrcnt_q[c0] - w0, cmd_wrcnt_q[c0+1] - w0); end
        end
        n_tests++; if (done_cyc !== last_cmd_cyc + 2) begin n_fail++; $display("FAIL wr_done_timing: got %0d, expected %0d", done_cyc, last_cmd_cyc + 2); end
        n_tests++; if (busy !== 1'b0 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL wr_end_state: got busy=%b dones=%0d, expected 0 1", busy, done_cnt - d0); end
    endtask

    task automatic test_read();
        int r0 = ob_q.size(), c0 = cmd_addr_q.size(), d0 = done_cnt, b0 = rd_idx, bad = 0;
        bit ok;
        bus.ob_count = 11'd0;
        bus.rd_empty = 1'b0;
        pulse_start(1'b1, 30'h0, 16'd3);
        wait_done(d0, 2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rd_done_timeout: got no done, expected done"); end
        n_tests++; if (ob_q.size() - r0 !== 96) begin n_fail++; $display("FAIL rd_count: got %0d, expected 96", ob_q.size() - r0); end
        for (int i = 0; i < 96; i++)
            if (r0 + i >= ob_q.size() || ob_q[r0+i] !== 32'hB000_0000 + 32'(b0 + i)) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rd_order: got %0d bad words, expected 0", bad); end
        n_tests++; if (cmd_addr_q.size() - c0 !== 3) begin n_fail++; $display("FAIL rd_cmd_count: got %0d, expected 3", cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h0 || cmd_addr_q[c0+1] !== 32'h80 || cmd_addr_q[c0+2] !== 32'h100) begin n_fail++; $display("FAIL rd_cmd_addr: got %h %h %h, expected 0 80 100", cmd_addr_q[c0], cmd_addr_q[c0+1], cmd_addr_q[c0+2]); end
            n_tests++; if (cmd_instr_q[c0] !== 3'b001 || cmd_instr_q[c0+2] !== 3'b001) begin n_fail++; $display("FAIL rd_cmd_instr: got %b %b, expected 001 001", cmd_instr_q[c0], cmd_instr_q[c0+2]); end
        end
        n_tests++; if (done_cyc !== last_ob_cyc + 1) begin n_fail++; $display("FAIL rd_done_timing: got %0d, expected %0d", done_cyc, last_ob_cyc + 1); end
    endtask

    task automatic test_backpressure();
        int w0 = wr_q.size(), c0 = cmd_addr_q.size(), d0 = done_cnt, b0 = ib_word, v0 = wr_viol, bad = 0;
        bit ok;
        bus.ib_count = 11'd64;
        bus.cmd_full = 1'b1;
        wr_toggle = 1'b1;
        pulse_start(1'b0, 30'h200, 16'd2);
        for (int i = 0; i < 500 && wr_q.size() - w0 < 32; i++) tick(1);
        tick(10);
        n_tests++; if (cmd_addr_q.size() - c0 !== 0) begin n_fail++; $display("FAIL bp_cmd_held: got %0d cmds, expected 0", cmd_addr_q.size() - c0); end
        bus.cmd_full = 1'b0;
        wait_done(d0, 2000, ok);
        wr_toggle = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got no done, expected done"); end
        n_tests++; if (wr_viol - v0 !== 0) begin n_fail++; $display("FAIL bp_wr_while_full: got %0d, expected 0", wr_viol - v0); end
        n_tests++; if (wr_q.size() - w0 !== 64) begin n_fail++; $display("FAIL bp_wr_count: got %0d, expected 64", wr_q.size() - w0); end
        for (int i = 0; i < 64; i++)
            if (w0 + i >= wr_q.size() || wr_q[w0+i] !== 32'hA000_0000 + 32'(b0 + i)) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_wr_order: got %0d bad words, expected 0", bad); end
        n_tests++; if (cmd_addr_q.size() - c0 !== 2) begin n_fail++; $display("FAIL bp_cmd_count: got %0d, expected 2", cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h200 || cmd_addr_q[c0+1] !== 32'h280) begin n_fail++; $display("FAIL bp_cmd_addr: got %h %h, expected 200 280", cmd_addr_q[c0], cmd_addr_q[c0+1]); end
        end
    endtask

    task automatic test_ob_space_and_wrap();
        int c0 = cmd_addr_q.size(), d0 = done_cnt;
        bit ok;
        bus.ob_count = 11'd1000;
        pulse_start(1'b1, 30'h0, 16'd1);
        tick(20);
        n_tests++; if (cmd_addr_q.size() - c0 !== 0) begin n_fail++; $display("FAIL ob_1000_gate: got %0d cmds, expected 0", cmd_addr_q.size() - c0); end
        bus.ob_count = 11'd993;
        tick(10);
        n_tests++; if (cmd_addr_q.size() - c0 !== 0) begin n_fail++; $display("FAIL ob_993_gate: got %0d cmds, expected 0", cmd_addr_q.size() - c0); end
        bus.ob_count = 11'd992;
        wait_done(d0, 500, ok);
        n_tests++; if (!ok || cmd_addr_q.size() - c0 !== 1) begin n_fail++; $display("FAIL ob_992_go: got done=%b cmds=%0d, expected 1 1", ok, cmd_addr_q.size() - c0); end
        bus.ob_count = 11'd0;
        c0 = cmd_addr_q.size();
        d0 = done_cnt;
        pulse_start(1'b1, 30'h3FFF_FFC0, 16'd2);
        wait_done(d0, 1000, ok);
        n_tests++; if (!ok || cmd_addr_q.size() - c0 !== 2) begin n_fail++; $display("FAIL wrap_cmd_count: got done=%b cmds=%0d, expected 1 2", ok, cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h3FFF_FFC0 || cmd_addr_q[c0+1] !== 32'h40) begin n_fail++; $display("FAIL wrap_addr: got %h %h, expected 3fffffc0 40", cmd_addr_q[c0], cmd_addr_q[c0+1]); end
        end
    endtask

    task automatic test_zero_and_busy_start();
        int c0 = cmd_addr_q.size(), w0 = wr_q.size(), d0 = done_cnt;
        bit ok;
        pulse_start(1'b0, 30'h500, 16'd0);
        wait_done(d0, 20, ok);
        n_tests++; if (!ok || done_cyc !== start_cyc + 2) begin n_fail++; $display("FAIL zero_done_timing: got %0d, expected %0d", done_cyc - start_cyc, 2); end
        n_tests++; if (cmd_addr_q.size() - c0 !== 0 || wr_q.size() - w0 !== 0) begin n_fail++; $display("FAIL zero_no_traffic: got %0d cmds, expected 0", cmd_addr_q.size() - c0); end
        d0 = done_cnt;
        bus.ib_count = 11'd0;
        pulse_start(1'b0, 30'h600, 16'd1);
        tick(3);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_wait: got %b, expected 1", busy); end
        pulse_start(1'b1, 30'h700, 16'd5);
        tick(3);
        bus.ib_count = 11'd64;
        wait_done(d0, 500, ok);
        tick(20);
        n_tests++; if (cmd_addr_q.size() - c0 !== 1) begin n_fail++; $display("FAIL busy_ignore_count: got %0d cmds, expected 1", cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h600 || cmd_instr_q[c0] !== 3'b000) begin n_fail++; $display("FAIL busy_ignore_cmd: got %h/%b, expected 600/000", cmd_addr_q[c0], cmd_instr_q[c0]); end
        end
        n_tests++; if (done_cnt - d0 !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_end: got dones=%0d busy=%b, expected 1 0", done_cnt - d0, busy); end
    endtask

    task automatic test_reset_mid_job();
        int w0 = wr_q.size(), c0, d0 = done_cnt, b0, bad = 0;
        bit ok;
        bus.ib_count = 11'd64;
        pulse_start(1'b0, 30'h300, 16'd2);
        for (int i = 0; i < 200 && wr_q.size() - w0 < 10; i++) tick(1);
        reset = 1'b0;
        tick(1);
        n_tests++; if ({bus.ib_re, bus.wr_en, bus.cmd_en, bus.rd_en, bus.ob_we, busy, done} !== 7'b0) begin n_fail++; $display("FAIL midreset_outputs: got %b, expected 0000000", {bus.ib_re, bus.wr_en, bus.cmd_en, bus.rd_en, bus.ob_we, busy, done}); end
        n_tests++; if (bus.wr_data !== 32'h0 || bus.cmd_byte_addr !== 30'h0) begin n_fail++; $display("FAIL midreset_regs: got %h/%h, expected 0/0", bus.wr_data, bus.cmd_byte_addr); end
        tick(2);
        reset = 1'b1;
        tick(2);
        n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midreset_no_done: got %0d, expected %0d", done_cnt, d0); end
        w0 = wr_q.size(); c0 = cmd_addr_q.size(); b0 = ib_word;
        pulse_start(1'b0, 30'h40, 16'd1);
        wait_done(d0, 1000, ok);
        n_tests++; if (!ok || cmd_addr_q.size() - c0 !== 1) begin n_fail++; $display("FAIL post_reset_job: got done=%b cmds=%0d, expected 1 1", ok, cmd_addr_q.size() - c0); end
        else begin
            n_tests++; if (cmd_addr_q[c0] !== 32'h40) begin n_fail++; $display("FAIL post_reset_addr: got %h, expected 40", cmd_addr_q[c0]); end
        end
        for (int i = 0; i < 32; i++)
            if (w0 + i >= wr_q.size() || wr_q[w0+i] !== 32'hA000_0000 + 32'(b0 + i)) bad++;
        n_tests++; if (bad !== 0 || wr_q.size() - w0 !== 32) begin n_fail++; $display("FAIL post_reset_data: got %0d bad, %0d words, expected 0, 32", bad, wr_q.size() - w0); end
    endtask

    initial begin
        reset = 1'b0; calib_done = 1'b1; start = 1'b0; mode = 1'b0;
        start_addr = '0; burst_num = '0;
        bus.ib_count = '0; bus.ob_count = '0; bus.cmd_full = 1'b0; bus.rd_empty = 1'b0;
        tick(1);
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_ob_space_and_wrap();
        test_zero_and_busy_start();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
